data_mem_responder: RTL and testbench

- Memory-side responder for the datapath's load/store port.
- Accepts one word request at a time through a valid/ready handshake, stalls for a configurable number of wait states, then commits the write or returns read data with a one-cycle response pulse.
- Byte-lane ordering matches the datapath: lane 0 holds bits 31:24 (big-endian).
- Sits between the datapath's memory port and the on-chip data array; used as the multi-cycle data memory model.

---
 rtl/mem_pkg.sv | 34 +++
 rtl/data_mem_responder_if.sv | 27 ++
 rtl/wait_counter.sv | 29 ++
 rtl/data_mem_responder.sv | 121 ++++++++++++
 tb/tb_data_mem_responder.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the data memory responder.
// Contents: byte/word lane types (lane 0 = bits 31:24), FSM state enum,
// big-endian lane pack/unpack functions.
package mem_pkg;

   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned LANE_W     = 8;

   typedef logic [LANE_W-1:0] byte_lane_t;
   // Packed with an ascending range so lane 0 is the most significant byte.
   typedef byte_lane_t [0:WORD_BYTES-1] word_lanes_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } mem_state_t;

   // Lanes to word, lane 0 in bits 31:24.
   function automatic logic [31:0] pack_lanes(input word_lanes_t lanes);
      return {lanes[0], lanes[1], lanes[2], lanes[3]};
   endfunction

   // Word to lanes, bits 31:24 into lane 0.
   function automatic word_lanes_t unpack_word(input logic [31:0] word);
      word_lanes_t lanes;
      lanes[0] = word[31:24];
      lanes[1] = word[23:16];
      lanes[2] = word[15:8];
      lanes[3] = word[7:0];
      return lanes;
   endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store request/response bundle between the datapath and the responder.
// Signals: req_valid/req_we/req_addr/req_wdata (requester -> responder),
// req_ready/resp_valid/resp_rdata/resp_err (responder -> requester).
interface data_mem_responder_if #(
   parameter int unsigned XLEN = 32
);

   logic                 req_valid;
   logic                 req_we;
   logic [XLEN-1:0]      req_addr;
   mem_pkg::word_lanes_t req_wdata;
   logic                 req_ready;
   logic                 resp_valid;
   mem_pkg::word_lanes_t resp_rdata;
   logic                 resp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );

endinterface

// File: rtl/wait_counter.sv
// Loadable down-counter used to time the WAIT state.
// Ports: clk, rst (async active-high), load_i/load_val_i (load a new count),
// dec_i (decrement, saturating at zero), zero_o (count is zero).
module wait_counter (
   input  logic       clk,
   input  logic       rst,
   input  logic       load_i,
   input  logic [3:0] load_val_i,
   input  logic       dec_i,
   output logic       zero_o
);

   localparam int unsigned CNT_W = 4;

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_q <= count_q - CNT_W'(1);
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder: accepts one word request, waits LATENCY
// cycles, then commits the store or returns load data with a one-cycle pulse.
// Ports: clk, rst_b (async active-high reset), bus (slave side of
// data_mem_responder_if carrying the request/response handshake).
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 2
) (
   input  logic                 clk,
   input  logic                 rst_b,
   data_mem_responder_if.slave  bus
);

   localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
   localparam int unsigned WIDX_W   = XLEN - 2;
   localparam logic [3:0]  LOAD_VAL = 4'((LATENCY == 0) ? 0 : LATENCY - 1);

   mem_state_t        state_q;
   logic              we_q;
   logic [XLEN-1:0]   addr_q;
   logic [31:0]       wdata_q;
   logic              resp_valid_q;
   logic [31:0]       resp_rdata_q;
   logic              resp_err_q;
   logic [31:0]       mem_q [DEPTH_WORDS];

   logic              cur_we_c;
   logic [XLEN-1:0]   cur_addr_c;
   logic [31:0]       cur_wdata_c;
   logic              err_c;
   logic [IDX_W-1:0]  idx_c;
   logic              accept_c;
   logic              enter_resp_c;
   logic              cnt_zero_c;

   // With zero latency RESP is entered on the accept edge, so the request is
   // taken straight from the bus; otherwise from the latched copy.
   always_comb begin
      cur_we_c    = we_q;
      cur_addr_c  = addr_q;
      cur_wdata_c = wdata_q;
      if (state_q == IDLE) begin
         cur_we_c    = bus.req_we;
         cur_addr_c  = bus.req_addr;
         cur_wdata_c = pack_lanes(bus.req_wdata);
      end
      err_c = (cur_addr_c[1:0] != 2'b00) ||
              (cur_addr_c[XLEN-1:2] >= WIDX_W'(DEPTH_WORDS));
      idx_c = cur_addr_c[IDX_W+1:2];
   end

   assign accept_c     = (state_q == IDLE) && bus.req_valid;
   assign enter_resp_c = (accept_c && (LATENCY == 0)) ||
                         ((state_q == WAIT) && cnt_zero_c);

   wait_counter u_wait_counter (
      .clk        (clk),
      .rst        (rst_b),
      .load_i     (accept_c),
      .load_val_i (LOAD_VAL),
      .dec_i      (state_q == WAIT),
      .zero_o     (cnt_zero_c)
   );

   // FSM, request latch, response registers and data array.
   always_ff @(posedge clk or posedge rst_b) begin
      if (rst_b) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
         for (int i = 0; i < DEPTH_WORDS; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         resp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.req_valid) begin
                  we_q    <= bus.req_we;
                  addr_q  <= bus.req_addr;
                  wdata_q <= pack_lanes(bus.req_wdata);
                  state_q <= (LATENCY == 0) ? RESP : WAIT;
               end
            end
            WAIT: begin
               if (cnt_zero_c) begin
                  state_q <= RESP;
               end
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase

         if (enter_resp_c) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= err_c;
            resp_rdata_q <= (!cur_we_c && !err_c) ? mem_q[idx_c] : '0;
            if (cur_we_c && !err_c) begin
               mem_q[idx_c] <= cur_wdata_c;
            end
         end
      end
   end

   assign bus.req_ready  = (state_q == IDLE);
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = unpack_word(resp_rdata_q);
   assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (LATENCY 2, 0, 3) share the
// request drivers; sel chooses which one is driven and observed.
module tb_data_mem_responder;
   import mem_pkg::*;

   localparam int DEPTH = 256;

   logic clk;
   logic rst_l2, rst_l0, rst_l3;
   int   sel;
   logic        drv_valid, drv_we;
   logic [31:0] drv_addr;
   word_lanes_t drv_wdata;

   logic        obs_ready, obs_rv, obs_err;
   word_lanes_t obs_rd;

   int compared   = 0;
   int mismatched = 0;

   int          lat [3] = '{2, 0, 3};
   logic [31:0] model [3][DEPTH];

   data_mem_responder_if #(.XLEN(32)) bus_l2 ();
   data_mem_responder_if #(.XLEN(32)) bus_l0 ();
   data_mem_responder_if #(.XLEN(32)) bus_l3 ();

   assign bus_l2.req_valid = drv_valid && (sel == 0);
   assign bus_l0.req_valid = drv_valid && (sel == 1);
   assign bus_l3.req_valid = drv_valid && (sel == 2);
   assign bus_l2.req_we = drv_we;   assign bus_l0.req_we = drv_we;   assign bus_l3.req_we = drv_we;
   assign bus_l2.req_addr = drv_addr; assign bus_l0.req_addr = drv_addr; assign bus_l3.req_addr = drv_addr;
   assign bus_l2.req_wdata = drv_wdata; assign bus_l0.req_wdata = drv_wdata; assign bus_l3.req_wdata = drv_wdata;

   data_mem_responder #(.XLEN(32), .DEPTH_WORDS(DEPTH), .LATENCY(2)) u_l2 (
      .clk(clk), .rst_b(rst_l2), .bus(bus_l2.slave));
   data_mem_responder #(.XLEN(32), .DEPTH_WORDS(DEPTH), .LATENCY(0)) u_l0 (
      .clk(clk), .rst_b(rst_l0), .bus(bus_l0.slave));
   data_mem_responder #(.XLEN(32), .DEPTH_WORDS(DEPTH), .LATENCY(3)) u_l3 (
      .clk(clk), .rst_b(rst_l3), .bus(bus_l3.slave));

   always_comb begin
      case (sel)
         1: begin obs_ready = bus_l0.req_ready; obs_rv = bus_l0.resp_valid;
                  obs_rd = bus_l0.resp_rdata; obs_err = bus_l0.resp_err; end
         2: begin obs_ready = bus_l3.req_ready; obs_rv = bus_l3.resp_valid;
                  obs_rd = bus_l3.resp_rdata; obs_err = bus_l3.resp_err; end
         default: begin obs_ready = bus_l2.req_ready; obs_rv = bus_l2.resp_valid;
                  obs_rd = bus_l2.resp_rdata; obs_err = bus_l2.resp_err; end
      endcase
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

   // Reference: word-addressed array, error if misaligned or index past DEPTH.
   task automatic model_txn(input int d, input logic we, input logic [31:0] addr,
                            input logic [31:0] wd, output logic [31:0] exp_rd,
                            output logic exp_err);
      exp_err = ((addr % 4) != 0) || ((addr / 4) >= DEPTH);
      exp_rd  = 32'h0;
      if (!exp_err) begin
         if (we) model[d][addr / 4] = wd;
         else    exp_rd = model[d][addr / 4];
      end
   endtask

   task automatic model_clear(input int d);
      for (int i = 0; i < DEPTH; i++) model[d][i] = 32'h0;
   endtask

   // Issue one request on DUT d; entered and left just after a falling edge.
   task automatic txn(input int d, input logic we, input logic [31:0] addr,
                      input logic [31:0] wd, output int lat_seen, output word_lanes_t rd,
                      output logic err, output logic pulse_ok, output logic timed_out);
      int n;
      sel = d; timed_out = 1'b0; lat_seen = -1; rd = '0; err = 1'b0; pulse_ok = 1'b0;
      #1;
      n = 0;
      while (!obs_ready && n < 20) begin @(negedge clk); #1; n++; end
      if (!obs_ready) begin timed_out = 1'b1; return; end
      drv_valid = 1'b1; drv_we = we; drv_addr = addr; drv_wdata = wd;
      @(posedge clk);
      @(negedge clk);
      drv_valid = 1'b0;
      n = 0;
      while (!obs_rv && n < 40) begin @(negedge clk); n++; end
      if (!obs_rv) begin timed_out = 1'b1; return; end
      lat_seen = n; rd = obs_rd; err = obs_err;
      @(negedge clk);
      pulse_ok = !obs_rv;
   endtask

   task automatic test_reset();
      drv_valid = 1'b0; drv_we = 1'b0; drv_addr = '0; drv_wdata = '0; sel = 0;
      rst_l2 = 1'b1; rst_l0 = 1'b1; rst_l3 = 1'b1;
      for (int d = 0; d < 3; d++) model_clear(d);
      repeat (3) @(negedge clk);
      rst_l2 = 1'b0; rst_l0 = 1'b0; rst_l3 = 1'b0;
      for (int d = 0; d < 3; d++) begin
         sel = d;
         #1;
         compared++;
         if (obs_ready !== 1'b1 || obs_rv !== 1'b0 || obs_rd !== 32'h0 || obs_err !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_dut%0d: ready=%b rv=%b rd=%h err=%b, required 1 0 00000000 0",
                     d, obs_ready, obs_rv, obs_rd, obs_err);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_store_load();
      int l; word_lanes_t r; logic e, p, to; logic [31:0] er; logic ee;
      txn(0, 1'b1, 32'h10, 32'hDEADBEEF, l, r, e, p, to);
      model_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, er, ee);
      compared++;
      if (to || l !== 2 || e !== 1'b0 || r !== 32'h0 || !p) begin
         mismatched++;
         $display("FAIL store_0x10: lat=%0d err=%b rd=%h pulse=%b to=%b, required lat=2 err=0 rd=0 pulse=1",
                  l, e, r, p, to);
      end
      txn(0, 1'b0, 32'h10, 32'h0, l, r, e, p, to);
      model_txn(0, 1'b0, 32'h10, 32'h0, er, ee);
      compared++;
      if (to || l !== 2 || e !== 1'b0 || r !== 32'hDEADBEEF || r[0] !== 8'hDE || !p) begin
         mismatched++;
         $display("FAIL load_0x10: lat=%0d err=%b rd=%h pulse=%b to=%b, required lat=2 err=0 rd=deadbeef",
                  l, e, r, p, to);
      end
   endtask

   task automatic test_errors();
      int l; word_lanes_t r; logic e, p, to; logic [31:0] er; logic ee;
      txn(0, 1'b1, 32'h13, 32'h12345678, l, r, e, p, to);
      model_txn(0, 1'b1, 32'h13, 32'h12345678, er, ee);
      compared++;
      if (to || e !== 1'b1 || r !== 32'h0 || l !== 2) begin
         mismatched++;
         $display("FAIL store_misaligned: err=%b rd=%h lat=%0d to=%b, required err=1 rd=0 lat=2", e, r, l, to);
      end
      txn(0, 1'b0, 32'h10, 32'h0, l, r, e, p, to);
      model_txn(0, 1'b0, 32'h10, 32'h0, er, ee);
      compared++;
      if (to || e !== ee || r !== er) begin
         mismatched++;
         $display("FAIL load_after_bad_store: err=%b rd=%h, required err=%b rd=%h", e, r, ee, er);
      end
      txn(0, 1'b0, 32'h400, 32'h0, l, r, e, p, to);
      model_txn(0, 1'b0, 32'h400, 32'h0, er, ee);
      compared++;
      if (to || e !== 1'b1 || r !== 32'h0 || !p) begin
         mismatched++;
         $display("FAIL load_out_of_range: err=%b rd=%h pulse=%b, required err=1 rd=0 pulse=1", e, r, p);
      end
   endtask

   task automatic test_handshake();
      logic [31:0] er; logic ee;
      model_txn(1, 1'b0, 32'h10, 32'h0, er, ee);
      sel = 1;
      drv_we = 1'b0; drv_addr = 32'h10; drv_wdata = '0; drv_valid = 1'b1;
      #1;
      for (int i = 0; i < 6; i++) begin
         compared++;
         if (obs_ready !== ((i % 2) == 0) || obs_rv !== ((i % 2) == 1) ||
             (obs_rv === 1'b1 && (obs_rd !== er || obs_err !== 1'b0))) begin
            mismatched++;
            $display("FAIL handshake_cycle%0d: ready=%b rv=%b rd=%h, required ready=%b rv=%b rd=%h",
                     i, obs_ready, obs_rv, obs_rd, (i % 2) == 0, (i % 2) == 1, er);
         end
         @(negedge clk); #1;
      end
      drv_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_wait();
      int l; word_lanes_t r; logic e, p, to; logic [31:0] er; logic ee;
      sel = 2;
      #1;
      drv_we = 1'b1; drv_addr = 32'h20; drv_wdata = 32'hCAFEF00D; drv_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      drv_valid = 1'b0;
      @(negedge clk);
      rst_l3 = 1'b1;
      model_clear(2);
      for (int i = 0; i < 6; i++) begin
         if (i == 2) rst_l3 = 1'b0;
         #1;
         compared++;
         if (obs_rv !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_mid_wait_rv%0d: rv=%b, required 0", i, obs_rv);
         end
         @(negedge clk);
      end
      txn(2, 1'b0, 32'h20, 32'h0, l, r, e, p, to);
      model_txn(2, 1'b0, 32'h20, 32'h0, er, ee);
      compared++;
      if (to || r !== 32'h0 || e !== 1'b0 || l !== 3) begin
         mismatched++;
         $display("FAIL load_after_reset_0x20: rd=%h err=%b lat=%0d to=%b, required rd=0 err=0 lat=3",
                  r, e, l, to);
      end
   endtask

   task automatic test_lane_order();
      int l; word_lanes_t r; logic e, p, to; logic [31:0] er; logic ee;
      logic [7:0] b0, b1, b2, b3;
      b0 = 8'h01; b1 = 8'h02; b2 = 8'h03; b3 = 8'h04;
      txn(0, 1'b1, 32'h0, {b0, b1, b2, b3}, l, r, e, p, to);
      model_txn(0, 1'b1, 32'h0, {b0, b1, b2, b3}, er, ee);
      txn(0, 1'b0, 32'h0, 32'h0, l, r, e, p, to);
      model_txn(0, 1'b0, 32'h0, 32'h0, er, ee);
      compared++;
      if (to || r[0] !== 8'h01 || r[3] !== 8'h04 || r !== 32'h01020304) begin
         mismatched++;
         $display("FAIL lane_order: lane0=%h lane3=%h word=%h, required 01 04 01020304", r[0], r[3], r);
      end
   endtask

   task automatic test_back_to_back();
      int l; word_lanes_t r; logic e, p, to; logic [31:0] er; logic ee;
      txn(0, 1'b1, 32'h4, 32'h11111111, l, r, e, p, to);
      model_txn(0, 1'b1, 32'h4, 32'h11111111, er, ee);
      txn(0, 1'b1, 32'h8, 32'h22222222, l, r, e, p, to);
      model_txn(0, 1'b1, 32'h8, 32'h22222222, er, ee);
      txn(0, 1'b0, 32'h4, 32'h0, l, r, e, p, to);
      compared++;
      if (to || r !== 32'h11111111 || e !== 1'b0) begin
         mismatched++;
         $display("FAIL b2b_load_0x4: rd=%h err=%b, required 11111111 0", r, e);
      end
      txn(0, 1'b0, 32'h8, 32'h0, l, r, e, p, to);
      compared++;
      if (to || r !== 32'h22222222 || e !== 1'b0) begin
         mismatched++;
         $display("FAIL b2b_load_0x8: rd=%h err=%b, required 22222222 0", r, e);
      end
   endtask

   task automatic test_random();
      int l; word_lanes_t r; logic e, p, to; logic [31:0] er; logic ee;
      int d; logic we; logic [31:0] addr, wd;
      for (int i = 0; i < 80; i++) begin
         d    = i % 2;
         we   = 1'($urandom_range(0, 1));
         wd   = $urandom;
         if ($urandom_range(0, 7) == 0) addr = $urandom;
         else addr = 32'($urandom_range(0, 31) * 4) |
                     (($urandom_range(0, 5) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
         txn(d, we, addr, wd, l, r, e, p, to);
         model_txn(d, we, addr, wd, er, ee);
         compared++;
         if (to || l !== lat[d] || e !== ee || r !== er || !p) begin
            mismatched++;
            $display("FAIL random%0d dut%0d we=%b addr=%h: lat=%0d err=%b rd=%h pulse=%b, required lat=%0d err=%b rd=%h",
                     i, d, we, addr, l, e, r, p, lat[d], ee, er);
         end
      end
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_errors();
      test_handshake();
      test_reset_mid_wait();
      test_lane_order();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
